// File: rtl/tpu_pkg.sv
// Shared constants and types for the systolic-array output path.
package tpu_pkg;

  localparam int DATA_W          = 16;
  localparam int RESULTS_PER_SET = 4;
  localparam int RAW_BYTES       = 8;
  localparam int SAT_BYTES       = 4;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/sat_int8.sv
// Combinational clamp of a signed W-bit value to signed int8.
module sat_int8 #(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [7:0]   dout
);

  localparam logic signed [W-1:0] MAX_V = W'(127);
  localparam logic signed [W-1:0] MIN_V = W'(-128);

  always_comb begin
    if ($signed(din) > MAX_V) begin
      dout = 8'h7f;
    end else if ($signed(din) < MIN_V) begin
      dout = 8'h80;
    end else begin
      dout = din[7:0];
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Buffers finished 2x2 result sets and streams them to the host as bytes.
// state | meaning
// IDLE  | nothing loaded; loads the head set once level != 0
// SEND  | presenting bytes of the loaded set under valid/ready
module result_serializer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          c00,
  input  logic [DATA_W-1:0]          c01,
  input  logic [DATA_W-1:0]          c10,
  input  logic [DATA_W-1:0]          c11,
  output logic                       cap_ready,
  input  logic                       sat_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       ovf_clr
);
  import tpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef logic [RESULTS_PER_SET-1:0][DATA_W-1:0] set_t;

  set_t                            mem [DEPTH];
  set_t                            cap_set;
  set_t                            load_set;
  set_t                            src_set;
  set_t                            set_q;
  state_t                          state;
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [PTR_W-1:0]                rd_ptr_nxt;
  logic                            mode_q;
  logic                            src_mode;
  logic [2:0]                      idx;
  logic [2:0]                      src_idx;
  logic [3:0]                      src_n;
  logic                            src_last;
  logic [7:0]                      src_byte;
  logic [RESULTS_PER_SET-1:0][7:0] sat_byte;
  logic                            push;
  logic                            drop;
  logic                            fire;
  logic                            pop;
  logic                            load_idle;
  logic                            load_chain;
  logic                            load;

  assign cap_set    = {c11, c10, c01, c00};
  assign cap_ready  = (level != LVL_W'(DEPTH));
  assign push       = cap_valid && cap_ready;
  assign drop       = cap_valid && !cap_ready;
  assign fire       = out_valid && out_ready;
  assign pop        = fire && out_last;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign load_idle  = (state == IDLE) && (level != '0);
  // A set captured on the final-byte cycle is taken straight from the inputs so no bubble appears.
  assign load_chain = pop && ((level > LVL_W'(1)) || push);
  assign load       = load_idle || load_chain;

  always_comb begin
    load_set = cap_set;
    if (load_idle) begin
      load_set = mem[rd_ptr];
    end else if (level > LVL_W'(1)) begin
      load_set = mem[rd_ptr_nxt];
    end
  end

  always_comb begin
    src_set  = load ? load_set : set_q;
    src_mode = load ? sat_mode : mode_q;
    src_idx  = load ? 3'd0 : idx + 3'd1;
    src_n    = src_mode ? 4'(SAT_BYTES) : 4'(RAW_BYTES);
    src_last = ({1'b0, src_idx} == src_n - 4'd1);
    if (src_mode) begin
      src_byte = sat_byte[src_idx[1:0]];
    end else begin
      src_byte = src_set[src_idx[2:1]][{src_idx[0], 3'b000} +: 8];
    end
  end

  for (genvar i = 0; i < RESULTS_PER_SET; i++) begin : g_sat
    sat_int8 #(.W(DATA_W)) u_sat (
      .din  (src_set[i]),
      .dout (sat_byte[i])
    );
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cap_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      set_q     <= '0;
      mode_q    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (load) begin
        state     <= SEND;
        set_q     <= src_set;
        mode_q    <= src_mode;
        idx       <= src_idx;
        out_valid <= 1'b1;
        out_data  <= src_byte;
        out_last  <= src_last;
      end else if (pop) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else if (fire) begin
        idx      <= src_idx;
        out_data <= src_byte;
        out_last <= src_last;
      end
    end
  end

endmodule
